// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared types and constants for the RAM arbiter.
// Holds the FSM state enum, RAM geometry and port-index constants.
package ram_arbiter_pkg;

    localparam int RAM_ADDR_W = 14;
    localparam int RAM_DATA_W = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

endpackage

// File: rtl/ram_arbiter_pick.sv
// ram_arbiter_pick: combinational winner select between two requesters.
// Ports: m0_req_i, m1_req_i, last_grant_i in; valid_o, idx_o out.
// Macro RAM_ARBITER_ROUND_ROBIN_EN: defined = round robin on ties,
// undefined = fixed priority (port 0 wins, last_grant_i ignored).
module ram_arbiter_pick
    import ram_arbiter_pkg::*;
(
    input  logic m0_req_i,
    input  logic m1_req_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic idx_o
);

    always_comb begin
        valid_o = m0_req_i | m1_req_i;
        idx_o   = PORT0;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        if (m0_req_i && m1_req_i) begin
            // tie goes to the port that did not win last time
            idx_o = ~last_grant_i;
        end else if (m1_req_i) begin
            idx_o = PORT1;
        end
`else
        if (!m0_req_i && m1_req_i) begin
            idx_o = PORT1;
        end
`endif
    end

`ifndef RAM_ARBITER_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = last_grant_i;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-ported RAM between two bus masters,
// serialising requests into IDLE -> ACCESS -> ACK sequences.
// Ports: clk, rst_n (async, active low); per master mN_req/we/addr/wdata
// in, mN_ack/mN_rdata out; busy; RAM side address_bus, data_bus
// (tri-stated unless writing), r, w.
// Macro RAM_ARBITER_ROUND_ROBIN_EN selects round-robin tie breaking.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] address_bus,
    inout  wire  [DATA_W-1:0] data_bus,
    output logic              r,
    output logic              w
);

    state_e            state_q, state_d;
    logic              idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] abus_q, abus_d;
    logic              r_q, r_d;
    logic              w_q, w_d;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic              last_grant;

    logic              pick_valid;
    logic              pick_idx;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic last_q, last_d;
    assign last_grant = last_q;
`else
    assign last_grant = PORT1;
`endif

    ram_arbiter_pick u_pick (
        .m0_req_i     (m0_req),
        .m1_req_i     (m1_req),
        .last_grant_i (last_grant),
        .valid_o      (pick_valid),
        .idx_o        (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        abus_d  = '0;
        r_d     = 1'b0;
        w_d     = 1'b0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    idx_d   = pick_idx;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
                    last_d  = pick_idx;
`endif
                    // strobes/address are loaded here so they are
                    // straight register outputs during ACCESS
                    if (pick_idx == PORT1) begin
                        wdata_d = m1_wdata;
                        abus_d  = m1_addr;
                        w_d     = m1_we;
                        r_d     = ~m1_we;
                    end else begin
                        wdata_d = m0_wdata;
                        abus_d  = m0_addr;
                        w_d     = m0_we;
                        r_d     = ~m0_we;
                    end
                end
            end
            ACCESS: begin
                state_d = ACK;
                if (r_q) begin
                    if (idx_q == PORT1) begin
                        rd1_d = data_bus;
                    end else begin
                        rd0_d = data_bus;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= PORT0;
            wdata_q <= '0;
            abus_q  <= '0;
            r_q     <= 1'b0;
            w_q     <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            abus_q  <= abus_d;
            r_q     <= r_d;
            w_q     <= w_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign busy        = (state_q != IDLE);
    assign m0_ack      = (state_q == ACK) && (idx_q == PORT0);
    assign m1_ack      = (state_q == ACK) && (idx_q == PORT1);
    assign m0_rdata    = rd0_q;
    assign m1_rdata    = rd1_q;
    assign address_bus = abus_q;
    assign r           = r_q;
    assign w           = w_q;
    assign data_bus    = w_q ? wdata_q : {DATA_W{1'bz}};

endmodule
